// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// master drives load/start/pause/tick; slave returns count and status.
interface countdown_timer_if #(
    parameter int DIGITS        = 2,
    parameter int COUNTER_WIDTH = 4
);
    logic                            load;
    logic [DIGITS*COUNTER_WIDTH-1:0] load_value;
    logic                            start;
    logic                            pause;
    logic                            tick;
    logic [DIGITS*COUNTER_WIDTH-1:0] count;
    logic                            running;
    logic                            done;

    modport master (
        output load, load_value, start, pause, tick,
        input  count, running, done
    );

    modport slave (
        input  load, load_value, start, pause, tick,
        output count, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Multi-digit modulo-N down-counter with start/pause control.
// Emits a one-cycle done pulse when the count reaches zero.
module countdown_timer #(
    parameter int MOD_VALUE     = 10,
    parameter int COUNTER_WIDTH = 4,
    parameter int DIGITS        = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    countdown_timer_if.slave  bus
);
    localparam int CW = COUNTER_WIDTH;
    localparam int W  = DIGITS * CW;
    localparam logic [CW-1:0] MAX_DIGIT = CW'(MOD_VALUE - 1);
    localparam logic [CW:0]   MOD_EXT   = (CW + 1)'(MOD_VALUE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_nxt;
    logic [W-1:0]   w_clamped;
    logic [W-1:0]   w_decr;
    logic           w_borrow;
    logic           w_decr_zero;
    logic           w_count_zero;
    logic           w_digits_ok;

    // Borrow ripples from digit 0 upward within one cycle
    always_comb begin
        w_clamped = '0;
        w_decr    = '0;
        w_borrow  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if ({1'b0, bus.load_value[d*CW +: CW]} >= MOD_EXT)
                w_clamped[d*CW +: CW] = MAX_DIGIT;
            else
                w_clamped[d*CW +: CW] = bus.load_value[d*CW +: CW];

            if (!w_borrow) begin
                w_decr[d*CW +: CW] = r_count[d*CW +: CW];
            end else if (r_count[d*CW +: CW] == '0) begin
                w_decr[d*CW +: CW] = MAX_DIGIT;
            end else begin
                w_decr[d*CW +: CW] = r_count[d*CW +: CW] - CW'(1);
                w_borrow           = 1'b0;
            end
        end
        w_decr_zero  = (w_decr == '0);
        w_count_zero = (r_count == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (bus.load) begin
            w_state_nxt = IDLE;
            w_count_nxt = w_clamped;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!bus.pause && bus.start && !w_count_zero)
                        w_state_nxt = RUN;
                end
                RUN: begin
                    if (bus.pause) begin
                        w_state_nxt = PAUSED;
                    end else if (bus.tick) begin
                        w_count_nxt = w_decr;
                        if (w_decr_zero)
                            w_state_nxt = DONE;
                    end
                end
                PAUSED: begin
                    if (!bus.pause && bus.start)
                        w_state_nxt = RUN;
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.running = (r_state == RUN);
        bus.done    = (r_state == DONE);
    end

    assign bus.count = r_count;

    always_comb begin
        w_digits_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if ({1'b0, r_count[d*CW +: CW]} >= MOD_EXT)
                w_digits_ok = 1'b0;
        end
    end

    a_no_x: assert property (@(posedge clk) disable iff (!reset_n)
        !$isunknown({bus.count, bus.running, bus.done}));

    a_digit_range: assert property (@(posedge clk) disable iff (!reset_n)
        w_digits_ok);

    a_done_single: assert property (@(posedge clk) disable iff (!reset_n)
        bus.done |=> !bus.done);
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Multi-digit, loadable, modulo-N down-counter with start/pause control and a one-cycle done pulse.
- It is the counting-down counterpart to the team's modulo up-counter. Each digit counts MOD_VALUE-1 down to 0, wraps, and borrows from the next digit.
- Used for stopwatch/countdown displays and timeouts. Driven by a prescaled tick enable.

Parameters:
- MOD_VALUE, 10, modulus of every digit; each digit ranges 0..MOD_VALUE-1.
- COUNTER_WIDTH, 4, bits per digit; must satisfy 2^COUNTER_WIDTH >= MOD_VALUE.
- DIGITS, 2, number of cascaded digits; digit 0 is least significant (count[COUNTER_WIDTH-1:0]).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe.
- load_value  input  DIGITS*COUNTER_WIDTH  value captured on load, digit-packed.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  single-cycle decrement enable (from a prescaler).
- count  output  DIGITS*COUNTER_WIDTH  current digits, driven directly from registers.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all digits 0, state IDLE.
  - running=0, done=0, taking effect immediately without a clock edge.
  - Release is synchronous to clk.
- States: IDLE, RUN, PAUSED, DONE.
- Priority each edge: load > pause > start > tick.
- load (any state):
  - each digit <= load_value digit; a digit value >= MOD_VALUE clamps to MOD_VALUE-1.
  - next state IDLE; done=0; a tick in the same cycle is ignored.
- IDLE:
  - start with count != 0 -> RUN.
  - start with count == 0 -> stay IDLE (no done pulse).
  - tick ignored.
- RUN, on tick:
  - digit 0 decrements.
  - A digit at 0 that receives a borrow wraps to MOD_VALUE-1 and propagates the borrow to the next digit. The borrow chain is combinational and resolves in the same cycle.
  - If the post-decrement count is all-zero, next state is DONE.
  - count never wraps from all-zero; it is never all-zero in RUN.
- RUN, other inputs:
  - pause -> PAUSED, no decrement that edge even if tick is high.
  - start in RUN has no effect.
- PAUSED:
  - count held; tick ignored.
  - start (without pause) -> RUN; pause and start together -> stay PAUSED.
- DONE:
  - count held at all-zero; done=1 for exactly this one cycle.
  - Unconditionally -> IDLE next edge unless load is asserted (load still wins).
  - start in DONE is ignored.
- Output decode: running = (state==RUN); done = (state==DONE); both decoded from the state register.
- Latency:
  - count changes on the same edge that samples tick.
  - done is high the cycle immediately after the edge where count became zero.
- Assertions: no X on outputs after reset; count digits always < MOD_VALUE; done never high for two consecutive cycles.

Test Plan (MOD_VALUE=10, COUNTER_WIDTH=4, DIGITS=2; count shown as hex digit pairs):
- Reset: pulse reset_n low between edges -> count=8'h00, running=0, done=0 immediately; start with no load -> remains IDLE.
- Full countdown:
  - load 8'h12, start, then 12 spaced ticks -> count 12,11,10,09,...,01,00.
  - The 10->09 step verifies wrap plus borrow.
  - done=1 for exactly one cycle after the 12th tick, then IDLE with running=0.
- Pause/resume:
  - load 8'h05, start, 2 ticks -> 8'h03; pause, 5 ticks -> count stays 8'h03.
  - start, 3 ticks -> 8'h00 and a single done pulse.
  - Also check pause+tick on the same edge -> no decrement.
- Load during RUN: count at 8'h07, assert load with 8'h20 and tick together -> count=8'h20, state IDLE, later ticks ignored until start.
- Clamp: load 8'hAF -> count=8'h99; start, one tick -> 8'h98.
- Async reset mid-RUN: at count 8'h34, drop reset_n mid-cycle -> count=8'h00 and running=0 before the next edge; no done pulse after release.
